// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage responder for decoded load/store instructions. It accepts one
// load or store from EX/MEM and turns it into a word-aligned request on a
// valid/ready data-memory port, with byte-lane write enables. Load data is
// returned sign- or zero-extended. The pipeline is stalled until the access
// completes. Misaligned or illegal requests and load response timeouts are
// reported as one-cycle pulses.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ex_valid          EX/MEM holds a valid instruction
//   opcode            LB/LH/LW/LBU/LHU/SB/SH/SW opcode
//   mem_rd, mem_wrt   load / store request from decode
//   addr, store_data  byte address and right-justified store value
//   stall             freeze PC and pipeline registers
//   load_data         extended load result, qualified by load_valid
//   misaligned        fault pulse: misaligned or illegal request
//   timeout           fault pulse: no load response in time
//   dmem_*            data-memory request/response port
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,  // 0 disables the timeout
  parameter int CNT_W          = 8     // 2**CNT_W > TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  opcode,
  input  logic        mem_rd,
  input  logic        mem_wrt,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        timeout,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state;
  logic [5:0]        op_q;
  logic [31:0]       addr_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q;
  logic              is_load_q;
  logic [CNT_W-1:0]  cnt;

  // Decode of the incoming instruction.
  logic        is_load_op, is_store_op, is_half, is_word;
  logic        mem_op, illegal, unaligned, accept;
  logic [3:0]  we_d;
  logic [31:0] wdata_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    we_d    = 4'b0000;
    wdata_d = 32'h0;
    case (opcode)
      OP_SB: begin
        we_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      OP_SH: begin
        we_d    = 4'b0011 << {addr[1], 1'b0};
        wdata_d = {2{store_data[15:0]}};
      end
      OP_SW: begin
        we_d    = 4'b1111;
        wdata_d = store_data;
      end
      default: ;
    endcase
  end

  assign is_load_op  = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                       (opcode == OP_LBU) || (opcode == OP_LHU);
  assign is_store_op = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
  assign is_half     = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
  assign is_word     = (opcode == OP_LW) || (opcode == OP_SW);

  assign mem_op    = ex_valid && (mem_rd || mem_wrt);
  // The request flag must agree with the opcode class; both flags is never legal.
  assign illegal   = (mem_rd && mem_wrt) || (mem_rd && !is_load_op) ||
                     (mem_wrt && !is_store_op);
  assign unaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign accept    = mem_op && !illegal && !unaligned;

  // Completion conditions of the outstanding access.
  logic store_done, resp_ok, to_hit;
  assign store_done = (state == S_REQ) && dmem_req_ready && !is_load_q;
  assign resp_ok    = (state == S_WAIT) && dmem_resp_valid;
  assign to_hit     = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) &&
                      !dmem_resp_valid && (cnt == TO_LAST);

  // Lane extraction uses the latched offset and opcode.
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_data;

  always_comb begin
    lane_b   = dmem_resp_data[8*addr_q[1:0] +: 8];
    lane_h   = addr_q[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];
    ext_data = dmem_resp_data;
    case (op_q)
      OP_LB:   ext_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ext_data = {24'h0, lane_b};
      OP_LH:   ext_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ext_data = {16'h0, lane_h};
      default: ext_data = dmem_resp_data;
    endcase
  end

  // Outputs are decoded from state so the pipeline sees stall release and
  // load data in the completing cycle; reset forces every output low.
  assign stall = !rst && (((state == S_IDLE) && accept) ||
                          ((state == S_REQ)  && !store_done) ||
                          ((state == S_WAIT) && !resp_ok && !to_hit));
  assign misaligned     = !rst && (state == S_IDLE) && mem_op && !accept;
  assign timeout        = !rst && to_hit;
  assign load_valid     = !rst && resp_ok;
  assign load_data      = load_valid ? ext_data : 32'h0;
  assign dmem_req_valid = !rst && (state == S_REQ);
  assign dmem_addr      = dmem_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_we        = dmem_req_valid ? we_q : 4'b0000;
  assign dmem_wdata     = dmem_req_valid ? wdata_q : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      // NOTE: the latched request fields are reset too, so nothing stale can
      // reach the memory port before the first accepted instruction.
      op_q      <= 6'h0;
      addr_q    <= 32'h0;
      we_q      <= 4'h0;
      wdata_q   <= 32'h0;
      is_load_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= opcode;
            addr_q    <= addr;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            is_load_q <= mem_rd;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            if (is_load_q) begin
              cnt   <= '0;
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (dmem_resp_valid || to_hit) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage responder for the load/store control signals (mem_rd, mem_wrt, opcode) produced by instruction decode. It receives one load/store per instruction from EX/MEM and turns it into a word-aligned request with byte-lane write enables on a valid/ready data-memory port. It returns sign- or zero-extended load data and holds the pipeline stalled until each access completes. Misaligned accesses and response timeouts are reported as one-cycle fault pulses.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before a load is aborted; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX/MEM stage holds a valid instruction
opcode  in  6  LB/LH/LW/LBU/LHU/SB/SH/SW opcode from Opcode.vh
mem_rd  in  1  load request from decode
mem_wrt  in  1  store request from decode
addr  in  32  byte address (ALU result)
store_data  in  32  rt value, right-justified
stall  out  1  freeze PC and pipeline registers
load_data  out  32  extended load result
load_valid  out  1  load_data valid this cycle
misaligned  out  1  one-cycle fault pulse: alignment or illegal request
timeout  out  1  one-cycle fault pulse: response timeout
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_we  out  4  byte-lane write enables; 0 for loads
dmem_wdata  out  32  store data replicated into the lanes
dmem_resp_valid  in  1  load response valid
dmem_resp_data  in  32  load response word

Behaviour:
- Byte lanes: lane n = bits [8n+7:8n]; addr[1:0]=n selects lane n (little-endian). Halfword at addr[1]=h occupies lanes {2h+1,2h}.
- Store enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<(2*addr[1]); SW 4'b1111. dmem_wdata: SB {4{sd[7:0]}}, SH {2{sd[15:0]}}, SW sd.
- Load extraction: select lane(s) via the latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Alignment: a halfword op with addr[0]=1 or a word op with addr[1:0]!=0 is misaligned. mem_rd&&mem_wrt both high, or a mem op with a non-load/store opcode, is illegal.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - ex_valid&&(mem_rd||mem_wrt) and legal/aligned: latch opcode, addr, we, wdata, and load/store flag; go to REQ. stall=1 combinationally in this cycle.
  - Misaligned or illegal: misaligned=1 for that cycle, stall=0, no request issued, stay in IDLE.
  - Otherwise stall=0.
- REQ: dmem_req_valid=1 with stable latched fields until dmem_req_ready.
  - Store handshake: completes; stall=0 that cycle; go to IDLE.
  - Load handshake: go to WAIT; clear the counter; stall=1.
- WAIT:
  - dmem_resp_valid: load_valid=1, load_data=extract(dmem_resp_data) combinationally in that same cycle; stall=0; go to IDLE.
  - Otherwise the counter increments. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no response: timeout=1, load_valid=0, stall=0, go to IDLE.
- Latency: store = 1 + wait-for-ready cycles (minimum 2 cycles with stall high for 1). Load = 2 + memory latency (minimum 3 cycles with stall high for 2).
- Input changes while in REQ or WAIT are ignored. The instruction advances only on the cycle stall=0.
- dmem_resp_valid outside WAIT is ignored.
- Exactly one access is outstanding at any time.
- Reset (any state): state=IDLE, counter=0. All outputs are 0 (stall, load_valid, load_data, misaligned, timeout, dmem_req_valid, dmem_we, dmem_addr, dmem_wdata). Data memory shares rst, so no in-flight response survives reset.

Test Plan:
- SB addr=0x1003 sd=0x000000AB, ready=1 -> dmem_addr=0x1000, dmem_we=4'b1000, dmem_wdata=0xABABABAB; stall high 1 cycle.
- LB addr=0x2001, resp=0x0000F200 after 2 cycles -> load_data=0xFFFFFFF2, load_valid 1 cycle; LBU same -> 0x000000F2. stall high 4 cycles total.
- LH addr=0x3002, resp=0x80017FFF -> load_data=0xFFFF8001; LHU -> 0x00008001; LW addr=0x3000 -> 0x80017FFF.
- LW addr=0x4002 -> misaligned pulse, dmem_req_valid never rises, stall=0. mem_rd=mem_wrt=1 -> misaligned pulse.
- SW with dmem_req_ready low 3 cycles -> req_valid and fields held stable 3 cycles; completes on the 4th cycle.
- LW with no response, TIMEOUT_CYCLES=4 -> timeout pulse after the 4th WAIT cycle, then IDLE. rst asserted in WAIT -> all outputs 0 next cycle, later resp_valid ignored.
